// File: rtl/apa102_ws2812_bridge.sv
// APA102 SPI receiver -> brightness/order remap -> double-buffered WS2812 single-wire transmitter.
// Latency: pin sck edge to bit capture <=4 clk; commit to led_o rising is 1 clk when tx is idle.
// Backpressure: none on the APA102 side; a committed frame not yet sent is superseded (drop pulse).
`timescale 1ns/1ps
module apa102_ws2812_bridge #(
  parameter int LED_CNT   = 7,
  parameter int T0H_CYC   = 4,
  parameter int T1H_CYC   = 8,
  parameter int BIT_CYC   = 12,
  parameter int RST_CYC   = 800,
  parameter int IDLE_CYC  = 4096,
  parameter int OUT_ORDER = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic sda,
  input  logic bri_en,
  output logic led_o,
  output logic busy,
  output logic frame_done,
  output logic drop
);

  localparam int IW   = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
  localparam int TXW  = LED_CNT * 24;
  localparam int BW   = (TXW > 1) ? $clog2(TXW) : 1;
  localparam int CMAX = (RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int ICW  = $clog2(IDLE_CYC + 1);

  localparam logic [0:0] RX_HUNT = 1'b0;
  localparam logic [0:0] RX_RECV = 1'b1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_HIGH  = 2'd1;
  localparam logic [1:0] TX_LOW   = 2'd2;
  localparam logic [1:0] TX_LATCH = 2'd3;

  // synchroniser / edge-detect state
  logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;
  logic sck_rise;

  // receiver state
  logic [0:0]     rx_st_q, rx_st_d;
  logic [4:0]     zcnt_q, zcnt_d;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [31:0]    word_q, word_d;
  logic           wvld_q, wvld_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic [23:0]    rx_buf_q [LED_CNT];
  logic [23:0]    rx_buf_d [LED_CNT];
  logic           pend_q, pend_d;
  logic           fd_q, fd_d;
  logic           drop_q, drop_d;

  // transmitter state
  logic [1:0]     tx_st_q, tx_st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  tx_bit_q, tx_bit_d;
  logic [TXW-1:0] tx_sr_q, tx_sr_d;
  logic           led_q, led_d;

  logic           copy;
  logic [CW-1:0]  th;
  logic [7:0]     b_s, g_s, r_s;
  logic [23:0]    pix;

  // (ch * (bri+1)) >> 5; bri=31 multiplies by 32 and is therefore the identity
  function automatic logic [7:0] scale(input logic [7:0] ch, input logic [4:0] b, input logic en);
    logic [13:0] prod;
    prod = 14'(ch) * 14'({1'b0, b} + 6'd1);
    return en ? prod[12:5] : ch;
  endfunction

  assign sck_rise = sck_sync_q & ~sck_prev_q;

  assign b_s = scale(word_q[23:16], word_q[28:24], bri_en);
  assign g_s = scale(word_q[15:8],  word_q[28:24], bri_en);
  assign r_s = scale(word_q[7:0],   word_q[28:24], bri_en);
  assign pix = (OUT_ORDER != 0) ? {r_s, g_s, b_s} : {g_s, r_s, b_s};

  // copy happens whenever a complete frame waits and the line is free
  assign copy = pend_q && (tx_st_q == TX_IDLE);
  assign th   = tx_sr_q[TXW-1] ? CW'(T1H_CYC) : CW'(T0H_CYC);

  assign led_o      = led_q;
  assign busy       = (tx_st_q != TX_IDLE);
  assign frame_done = fd_q;
  assign drop       = drop_q;

  // two-flop synchronisers plus previous-sample flop for sck edge detection
  always_comb begin
    sck_meta_d = sck;
    sck_sync_d = sck_meta_q;
    sck_prev_d = sck_sync_q;
    sda_meta_d = sda;
    sda_sync_d = sda_meta_q;
  end

  // receiver: start-frame hunt, word assembly, header checks and rx buffer writes
  always_comb begin
    rx_st_d    = rx_st_q;
    zcnt_d     = zcnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    wvld_d     = 1'b0;
    idx_d      = idx_q;
    idle_cnt_d = '0;
    rx_buf_d   = rx_buf_q;
    pend_d     = pend_q;
    fd_d       = 1'b0;
    drop_d     = 1'b0;
    if (copy) pend_d = 1'b0;
    if (rx_st_q == RX_HUNT) begin
      if (sck_rise) begin
        if (sda_sync_q) begin
          zcnt_d = '0;
        end else if (zcnt_q == 5'd31) begin
          rx_st_d = RX_RECV;
          zcnt_d  = '0;
          bcnt_d  = '0;
          idx_d   = '0;
        end else begin
          zcnt_d = zcnt_q + 5'd1;
        end
      end
    end else begin
      idle_cnt_d = idle_cnt_q + ICW'(1);
      if (wvld_q) begin
        if (word_q[31:29] == 3'b111) begin
          rx_buf_d[idx_q] = pix;
          // first pixel of a new frame overwrites a frame that never got sent
          if ((idx_q == '0) && pend_q && !copy) begin
            pend_d = 1'b0;
            drop_d = 1'b1;
          end
          if (idx_q == IW'(LED_CNT - 1)) begin
            fd_d    = 1'b1;
            pend_d  = 1'b1;
            rx_st_d = RX_HUNT;
            zcnt_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (word_q == '0) begin
          idx_d = '0;
        end else begin
          rx_st_d = RX_HUNT;
          zcnt_d  = '0;
        end
      end else if (sck_rise) begin
        word_d     = {word_q[30:0], sda_sync_q};
        bcnt_d     = bcnt_q + 5'd1;
        wvld_d     = (bcnt_q == 5'd31);
        idle_cnt_d = '0;
      end else if (idle_cnt_q == ICW'(IDLE_CYC - 1)) begin
        rx_st_d = RX_HUNT;
        zcnt_d  = '0;
      end
    end
  end

  // transmitter: per-bit high/low timing followed by the latch gap
  always_comb begin
    tx_st_d  = tx_st_q;
    cnt_d    = cnt_q + CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sr_d  = tx_sr_q;
    led_d    = led_q;
    case (tx_st_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (copy) begin
          for (int i = 0; i < LED_CNT; i++) begin
            tx_sr_d[TXW-1-24*i -: 24] = rx_buf_q[i];
          end
          tx_bit_d = '0;
          tx_st_d  = TX_HIGH;
          led_d    = 1'b1;
        end
      end
      TX_HIGH: begin
        if (cnt_q == th - CW'(1)) begin
          tx_st_d = TX_LOW;
          led_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      TX_LOW: begin
        if (cnt_q == CW'(BIT_CYC) - th - CW'(1)) begin
          cnt_d = '0;
          if (tx_bit_q == BW'(TXW - 1)) begin
            tx_st_d = TX_LATCH;
          end else begin
            tx_sr_d  = {tx_sr_q[TXW-2:0], 1'b0};
            tx_bit_d = tx_bit_q + BW'(1);
            tx_st_d  = TX_HIGH;
            led_d    = 1'b1;
          end
        end
      end
      TX_LATCH: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          tx_st_d = TX_IDLE;
          cnt_d   = '0;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // state registers; reset drives led_o low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_prev_q <= 1'b0;
      sda_meta_q <= 1'b0;
      sda_sync_q <= 1'b0;
      rx_st_q    <= RX_HUNT;
      zcnt_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      wvld_q     <= 1'b0;
      idx_q      <= '0;
      idle_cnt_q <= '0;
      rx_buf_q   <= '{default: '0};
      pend_q     <= 1'b0;
      fd_q       <= 1'b0;
      drop_q     <= 1'b0;
      tx_st_q    <= TX_IDLE;
      cnt_q      <= '0;
      tx_bit_q   <= '0;
      tx_sr_q    <= '0;
      led_q      <= 1'b0;
    end else begin
      sck_meta_q <= sck_meta_d;
      sck_sync_q <= sck_sync_d;
      sck_prev_q <= sck_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      rx_st_q    <= rx_st_d;
      zcnt_q     <= zcnt_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      wvld_q     <= wvld_d;
      idx_q      <= idx_d;
      idle_cnt_q <= idle_cnt_d;
      rx_buf_q   <= rx_buf_d;
      pend_q     <= pend_d;
      fd_q       <= fd_d;
      drop_q     <= drop_d;
      tx_st_q    <= tx_st_d;
      cnt_q      <= cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sr_q    <= tx_sr_d;
      led_q      <= led_d;
    end
  end

endmodule
